framebuffer_scan_reader: RTL and testbench



---
 rtl/framebuffer_scan_reader.sv | 161 ++++++++++++++++
 tb/tb_framebuffer_scan_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_scan_reader
// Purpose  : Raster-order frame reader over a fixed-latency BRAM port, with a
//            credit-limited prefetch FIFO feeding an x/y-tagged pixel stream.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_scan_reader #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int ADDR_BITS    = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int DEPTH        = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [15:0]           pix_x,
  output logic [15:0]           pix_y,
  output logic                  pix_eol,
  output logic                  pix_last
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  localparam logic [15:0]          c_x_max   = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0]          c_y_max   = 16'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] c_fw_a    = ADDR_BITS'(FRAME_WIDTH);
  localparam logic [c_ptr_w-1:0]   c_ptr_max = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0]   c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0]   c_one     = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [15:0]             r_rx;
  logic [15:0]             r_ry;
  logic [15:0]             r_ox;
  logic [15:0]             r_oy;

  // Reads in flight plus entries already buffered; bounded by DEPTH.
  logic [c_cnt_w-1:0]      r_outstanding;
  logic [c_cnt_w-1:0]      r_fifo_cnt;
  logic [READ_LATENCY-1:0] r_vld_sr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;

  logic                    w_issue;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_last_rd;
  logic                    w_start_ok;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_max) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_pop      = pix_valid && pix_ready;
  assign w_push     = r_vld_sr[READ_LATENCY-1];
  assign w_last_rd  = (r_rx == c_x_max) && (r_ry == c_y_max);
  // A pop this cycle frees a slot, so a full buffer can still issue.
  assign w_issue    = (r_state == ST_READ) && ((r_outstanding < c_depth) || w_pop);

  assign rd_en     = w_issue;
  assign rd_addr   = ADDR_BITS'(r_ry) * c_fw_a + ADDR_BITS'(r_rx);

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign pix_valid = (r_fifo_cnt != '0);
  assign pix_data  = r_mem[r_rd_ptr];
  assign pix_x     = r_ox;
  assign pix_y     = r_oy;
  assign pix_eol   = (r_ox == c_x_max);
  assign pix_last  = (r_ox == c_x_max) && (r_oy == c_y_max);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_READ;
      ST_READ:  if (w_issue && w_last_rd) w_state_next = ST_DRAIN;
      // Looking through the current pop lets done follow the last beat directly.
      ST_DRAIN: if ((r_outstanding == '0) || ((r_outstanding == c_one) && w_pop))
                  w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rx          <= '0;
      r_ry          <= '0;
      r_ox          <= '0;
      r_oy          <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_vld_sr      <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_vld_sr      <= (r_vld_sr << 1) | READ_LATENCY'(w_issue);
      r_outstanding <= r_outstanding + c_cnt_w'(w_issue) - c_cnt_w'(w_pop);
      r_fifo_cnt    <= r_fifo_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);

      if (w_start_ok) begin
        r_rx <= '0;
        r_ry <= '0;
      end else if (w_issue) begin
        if (r_rx == c_x_max) begin
          r_rx <= '0;
          r_ry <= (r_ry == c_y_max) ? '0 : r_ry + 16'd1;
        end else begin
          r_rx <= r_rx + 16'd1;
        end
      end

      if (w_start_ok) begin
        r_ox <= '0;
        r_oy <= '0;
      end else if (w_pop) begin
        if (r_ox == c_x_max) begin
          r_ox <= '0;
          r_oy <= (r_oy == c_y_max) ? '0 : r_oy + 16'd1;
        end else begin
          r_ox <= r_ox + 16'd1;
        end
      end
    end
  end

  // Storage needs no reset; occupancy is governed by the counters above.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_scan_reader
// Purpose  : Directed bench for framebuffer_scan_reader on an 8x4 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scan_reader;

  localparam int FW = 8;
  localparam int FH = 4;
  localparam int NPIX = FW * FH;
  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, busy, done, rd_en;
  logic [17:0] rd_addr;
  logic [15:0] rd_data, rd_p1;
  logic        pix_valid, pix_ready, pix_eol, pix_last;
  logic [15:0] pix_data, pix_x, pix_y;

  logic        start1, busy1, done1, rd_en1;
  logic [17:0] rd_addr1;
  logic [15:0] rd_data1;
  logic        pix_valid1, pix_ready1, pix_eol1, pix_last1;
  logic [15:0] pix_data1, pix_x1, pix_y1;

  int tests = 0;
  int fails = 0;
  int rd1_cnt = 0;

  always #5 clk = ~clk;

  framebuffer_scan_reader #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_last(pix_last)
  );

  framebuffer_scan_reader #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .pix_valid(pix_valid1), .pix_ready(pix_ready1), .pix_data(pix_data1),
    .pix_x(pix_x1), .pix_y(pix_y1), .pix_eol(pix_eol1), .pix_last(pix_last1)
  );

  // Framebuffer contents equal the low 16 address bits.
  always @(posedge clk) begin
    rd_p1    <= rd_addr[15:0];
    rd_data  <= rd_p1;
    rd_data1 <= rd_addr1[15:0];
    if (rd_en1) rd1_cnt <= rd1_cnt + 1;
  end

  typedef struct {
    int          cyc;
    logic        busy, done, rd_en;
    logic [17:0] addr;
    logic        valid;
    logic [15:0] data, x, y;
    logic        eol, last;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low through cycle 50;
  // 3: ready high with extra start pulses at cycles 10 and 30.
  task automatic run_frame(input int mode, output int beats, output int errs,
                           output int done_cyc, output int rd_stall, output int stall_bad);
    int n;
    n = 0; errs = 0; done_cyc = -1; rd_stall = 0; stall_bad = 0;
    start = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      if (c > 0) start = (mode == 3) && (c == 10 || c == 30);
      case (mode)
        1:       pix_ready = 1'($urandom_range(0, 1));
        2:       pix_ready = (c > 50);
        default: pix_ready = 1'b1;
      endcase
      #1;
      if (mode == 2 && c <= 50) begin
        if (rd_en) rd_stall++;
        if (pix_valid && pix_data != 16'd0) stall_bad++;
      end
      if (pix_valid && pix_ready) begin
        if (pix_data != 16'(n) || pix_x != 16'(n % FW) || pix_y != 16'(n / FW) ||
            pix_eol != ((n % FW) == FW - 1) || pix_last != (n == NPIX - 1))
          errs++;
        n++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    start = 1'b0;
    pix_ready = 1'b1;
    beats = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, errs, dcyc, rstall, sbad, idle_bad, first, bad;
    logic [127:0] act, exp;

    rst = 1'b1; start = 1'b0; pix_ready = 1'b1; start1 = 1'b0; pix_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state",
          {busy, done, rd_en, rd_addr, pix_valid, pix_eol, pix_last, pix_x, pix_y}, '0);

    // cyc busy done rd_en addr valid data x y eol last
    vecs[0]  = '{0,  1'b0, 1'b0, 1'b0, 18'd0,  1'b0, 16'd0,  16'd0, 16'd0, 1'b0, 1'b0};
    vecs[1]  = '{1,  1'b1, 1'b0, 1'b1, 18'd0,  1'b0, 16'd0,  16'd0, 16'd0, 1'b0, 1'b0};
    vecs[2]  = '{3,  1'b1, 1'b0, 1'b1, 18'd2,  1'b0, 16'd0,  16'd0, 16'd0, 1'b0, 1'b0};
    vecs[3]  = '{4,  1'b1, 1'b0, 1'b1, 18'd3,  1'b1, 16'd0,  16'd0, 16'd0, 1'b0, 1'b0};
    vecs[4]  = '{11, 1'b1, 1'b0, 1'b1, 18'd10, 1'b1, 16'd7,  16'd7, 16'd0, 1'b1, 1'b0};
    vecs[5]  = '{12, 1'b1, 1'b0, 1'b1, 18'd11, 1'b1, 16'd8,  16'd0, 16'd1, 1'b0, 1'b0};
    vecs[6]  = '{32, 1'b1, 1'b0, 1'b1, 18'd31, 1'b1, 16'd28, 16'd4, 16'd3, 1'b0, 1'b0};
    vecs[7]  = '{33, 1'b1, 1'b0, 1'b0, 18'd0,  1'b1, 16'd29, 16'd5, 16'd3, 1'b0, 1'b0};
    vecs[8]  = '{35, 1'b1, 1'b0, 1'b0, 18'd0,  1'b1, 16'd31, 16'd7, 16'd3, 1'b1, 1'b1};
    vecs[9]  = '{36, 1'b1, 1'b1, 1'b0, 18'd0,  1'b0, 16'd0,  16'd0, 16'd0, 1'b0, 1'b0};
    vecs[10] = '{37, 1'b0, 1'b0, 1'b0, 18'd0,  1'b0, 16'd0,  16'd0, 16'd0, 1'b0, 1'b0};

    begin
      int idx;
      idx = 0;
      for (int c = 0; c <= 37; c++) begin
        start = (c == 0);
        pix_ready = 1'b1;
        #1;
        if (idx < 11 && vecs[idx].cyc == c) begin
          act = {busy, done, rd_en, (rd_en ? rd_addr : 18'd0), pix_valid,
                 (pix_valid ? {pix_data, pix_x, pix_y, pix_eol, pix_last} : 50'd0)};
          exp = {vecs[idx].busy, vecs[idx].done, vecs[idx].rd_en, vecs[idx].addr,
                 vecs[idx].valid, vecs[idx].data, vecs[idx].x, vecs[idx].y,
                 vecs[idx].eol, vecs[idx].last};
          check($sformatf("vec_cyc%0d", c), act, exp);
          idx++;
        end
        if (c < 37) step();
      end
      start = 1'b0;
    end

    // Back-to-back frame: start in the IDLE cycle right after DONE.
    run_frame(0, beats, errs, dcyc, rstall, sbad);
    check("full_beats", beats, NPIX);
    check("full_data", errs, 0);
    check("full_done_cyc", dcyc, 36);
    step(); #1;
    check("busy_fall", {busy, done}, 2'b00);

    run_frame(2, beats, errs, dcyc, rstall, sbad);
    check("stall_rd_count", rstall, 4);
    check("stall_data_hold", sbad, 0);
    check("stall_beats", beats, NPIX);
    check("stall_data", errs, 0);
    check("stall_done_cyc", dcyc, 83);
    step();

    run_frame(1, beats, errs, dcyc, rstall, sbad);
    check("rand_beats", beats, NPIX);
    check("rand_data", errs, 0);
    check("rand_done_seen", dcyc >= 0, 1'b1);
    step();

    run_frame(3, beats, errs, dcyc, rstall, sbad);
    check("restart_beats", beats, NPIX);
    check("restart_data", errs, 0);
    check("restart_done_cyc", dcyc, 36);
    idle_bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(); #1;
      if (busy || pix_valid) idle_bad++;
    end
    check("restart_single_frame", idle_bad, 0);

    // Abort a frame with a one-cycle reset at cycle 20.
    start = 1'b1; pix_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_state",
          {busy, done, rd_en, rd_addr, pix_valid, pix_eol, pix_last, pix_x, pix_y}, '0);
    idle_bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (pix_valid || busy || done) idle_bad++;
    end
    check("midrst_no_stale", idle_bad, 0);
    run_frame(0, beats, errs, dcyc, rstall, sbad);
    check("midrst_fresh_beats", beats, NPIX);
    check("midrst_fresh_data", errs, 0);
    check("midrst_fresh_done", dcyc, 36);
    step();

    // Latency-1 build.
    first = -1;
    start1 = 1'b1; pix_ready1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) start1 = 1'b0;
      #1;
      if (pix_valid1) begin
        first = c;
        break;
      end
      step();
    end
    start1 = 1'b0;
    check("rl1_first_valid", first, 3);
    bad = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (!(pix_valid1 && pix_data1 == 16'(k))) bad++;
      if (k == NPIX - 1)
        check("rl1_last_tags", {pix_x1, pix_y1, pix_eol1, pix_last1}, {16'd7, 16'd3, 2'b11});
      step(); #1;
    end
    check("rl1_sustained", bad, 0);
    check("rl1_done", {done1, busy1, pix_valid1}, 3'b110);
    check("rl1_reads", rd1_cnt, NPIX);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
